lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Load/store unit that sits between the core's execute/memory stage and the word-organised data RAM. It accepts one byte-addressed RISC-V load or store at a time and converts it into word-addressed RAM transactions. It performs read-modify-write for sub-word stores and byte-lane extraction with sign or zero extension for loads. It returns a single-cycle response pulse and flags misaligned or illegal accesses.

## Interface
Parameters:
- ADDRESS_WIDTH, 14: width of the RAM word address.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse; there is no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid.
- mem_wEn  out  1  to RAM write enable.
- mem_addr  out  ADDRESS_WIDTH  word address = req_addr[ADDRESS_WIDTH+1:2]; higher bits ignored, so addresses wrap.
- mem_access_type  out  3  to RAM; 3'b010 for every access except the direct sub-word path.
- mem_dataIn  out  32  to RAM write data.
- mem_dataOut  in  32  from RAM; valid the cycle after the address edge.

## Operation
- Request fields are captured into internal registers on accept. All mem_* outputs are driven from state and captured registers, never from req_*.
- States:
  - IDLE
  - RD: read issued
  - DATA: mem_dataOut valid
  - WR: mem_wEn = 1
  - RESP: resp_valid = 1
- IDLE on accept:
  - Illegal or misaligned → RESP with err=1; no RAM access.
  - Load → RD.
  - SW → WR.
  - SB/SH → RD.
- Illegal: store funct3 other than 000/001/010; load funct3 011/110/111.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
- RD → DATA unconditionally.
- DATA, load → RESP. resp_rdata = selected lane of mem_dataOut, where lane = addr[1:0] for B and addr[1] for H.
  - B/H: sign-extended.
  - BU/HU: zero-extended.
  - W: whole word.
- DATA, store → WR. The write word is mem_dataOut with the addressed byte or halfword replaced by req_wdata[7:0] or req_wdata[15:0].
- WR → RESP. mem_wEn=1 for exactly one cycle, mem_access_type=010, mem_dataIn = merged word (SW: req_wdata).
- RESP → IDLE. resp_valid=1 and resp_err as computed. resp_rdata and resp_err are registered and held until the next RESP.
- Reset (asynchronous, any state):
  - State → IDLE, so req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0, mem_wEn=0, mem_addr=0, mem_dataIn=0, mem_access_type=010.
  - An in-flight access is abandoned with no response.
  - A reset asserted in WR may or may not commit that write; the bench does not check it.

## Timing
Accept edge = E0.
- Load: RD in cycle 1, DATA in cycle 2, resp_valid in cycle 3. Next accept is possible at the end of cycle 4.
- SW: WR in cycle 1, resp in cycle 2.
- SB/SH (RMW): RD in cycle 1, DATA in cycle 2, WR in cycle 3, resp in cycle 4.
- Error: resp in cycle 1.
- The RAM read in RD and the RAM write in WR target the same word, so no other master may write that word between them; the block assumes exclusive RAM ownership.

## Configuration
- LSU_DIRECT_SUBWORD_EN defined:
  - SB with addr[1:0]=00 and SH with addr[1:0]=00 skip RD/DATA and go straight to WR.
  - In WR, mem_access_type = 000 (SB) or 001 (SH) and mem_dataIn = req_wdata, so the RAM lane enables write only the low byte or low half.
  - Latency is the same as SW.
- LSU_DIRECT_SUBWORD_EN undefined: every SB/SH uses RMW with access type 010.

## Test plan
- Store and reload a word:
  - SW 0xDEADBEEF at 0x100, then LW 0x100 → resp_rdata=0xDEADBEEF, err=0.
  - mem_addr=0x40 during the write.
  - resp arrives 2 cycles after accept for the SW and 3 cycles after accept for the LW.
- Sub-word store, then loads:
  - After the word above, SB 0x5A at 0x102 → memory word 0xDE5ABEEF. With the macro undefined, mem_wEn is seen once, at cycle 3.
  - LB 0x103 → 0xFFFFFFDE.
  - LBU 0x103 → 0x000000DE.
  - LH 0x102 → 0xFFFFDE5A.
  - LHU 0x100 → 0x0000BEEF.
- Errors:
  - LW 0x101 → err=1, rdata=0, no mem_wEn.
  - SH 0x103 → err=1; the memory word is unchanged.
  - Load with funct3=011 → err=1.
  - All three respond one cycle after accept.
- Handshake:
  - Hold req_valid high with back-to-back requests → req_ready is low from cycle 1 through RESP.
  - Exactly one resp_valid pulse per accepted request.
- Reset mid-op: assert rst_n=0 in DATA of an LW → no resp_valid, all outputs at reset values, req_ready=1 immediately.
- Macro defined: SB 0x77 at 0x200 → WR in cycle 1 with mem_access_type=000 and mem_dataIn=0x00000077; reading the word back shows only byte 0 changed.

Source files
------------

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: byte-addressed RISC-V load/store to word RAM (RMW sub-word stores, extended loads).
// Latency: load 3, SW 2, RMW SB/SH 4, error 1 cycle(s) from accept to resp_valid; one request at a time.
// Backpressure: req_ready only in IDLE; response is a single-cycle pulse with no backpressure.
// Optional feature: LSU_DIRECT_SUBWORD_EN (word-aligned SB/SH written directly with RAM lane enables).
module lsu_mem_port #(
  parameter int ADDRESS_WIDTH = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [31:0]              req_addr,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [2:0]               mem_access_type,
  output logic [31:0]              mem_dataIn,
  input  logic [31:0]              mem_dataOut
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_DATA,
    S_WR,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  // Captured request; the RAM side only ever sees these, never live req_* inputs.
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [2:0]  cap_f3;
  logic [31:0] cap_wdata;
  logic        cap_direct;

  logic [31:0] wr_word;   // word presented on mem_dataIn during WR
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_illegal;
  logic        req_misal;
  logic        req_bad;
  logic        req_direct;
  logic [31:0] ld_data;
  logic [31:0] st_merge;
  logic        unused_addr_hi;

  assign accept = req_valid && req_ready;

  // Address bits above the RAM word address are deliberately dropped (addresses wrap).
  assign unused_addr_hi = ^cap_addr[31:ADDRESS_WIDTH+2];

  // Classify the incoming request: illegal funct3, misalignment, direct sub-word eligibility.
  always_comb begin
    req_illegal = 1'b0;
    req_misal   = 1'b0;
    req_direct  = 1'b0;
    if (req_we) begin
      req_illegal = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010);
    end else begin
      req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) begin
      req_misal = 1'b1;
    end
    if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00) begin
      req_misal = 1'b1;
    end
`ifdef LSU_DIRECT_SUBWORD_EN
    req_direct = req_we && (req_funct3 == 3'b000 || req_funct3 == 3'b001) &&
                 (req_addr[1:0] == 2'b00);
`else
    req_direct = 1'b0;
`endif
  end

  assign req_bad = req_illegal || req_misal;

  // Lane extraction with sign/zero extension for loads, and lane merge for RMW stores.
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b   = mem_dataOut[{cap_addr[1:0], 3'b000} +: 8];
    lane_h   = mem_dataOut[{cap_addr[1], 4'b0000} +: 16];
    ld_data  = mem_dataOut;
    st_merge = mem_dataOut;
    case (cap_f3[1:0])
      2'b00: begin
        ld_data = {{24{lane_b[7] && !cap_f3[2]}}, lane_b};
        st_merge[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
      end
      2'b01: begin
        ld_data = {{16{lane_h[15] && !cap_f3[2]}}, lane_h};
        st_merge[{cap_addr[1], 4'b0000} +: 16] = cap_wdata[15:0];
      end
      default: begin
        ld_data  = mem_dataOut;
        st_merge = cap_wdata;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt       = state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    mem_wEn         = 1'b0;
    mem_access_type = 3'b010;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_bad) begin
            state_nxt = S_RESP;
          end else if (req_we && (req_funct3 == 3'b010 || req_direct)) begin
            state_nxt = S_WR;
          end else begin
            state_nxt = S_RD;
          end
        end
      end
      S_RD: begin
        state_nxt = S_DATA;
      end
      S_DATA: begin
        state_nxt = cap_we ? S_WR : S_RESP;
      end
      S_WR: begin
        mem_wEn = 1'b1;
        if (cap_direct) begin
          mem_access_type = cap_f3;
        end
        state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture, write-word build and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_f3     <= 3'b000;
      cap_wdata  <= '0;
      cap_direct <= 1'b0;
      wr_word    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_we     <= req_we;
            cap_addr   <= req_addr;
            cap_f3     <= req_funct3;
            cap_wdata  <= req_wdata;
            cap_direct <= req_direct && !req_bad;
            wr_word    <= req_wdata;
            if (req_bad) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (cap_we) begin
            wr_word <= st_merge;
          end else begin
            rdata_q <= ld_data;
            err_q   <= 1'b0;
          end
        end
        S_WR: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr   = cap_addr[ADDRESS_WIDTH+1:2];
  assign mem_dataIn = wr_word;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed checks of lsu_mem_port against a behavioural word RAM.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_lsu_mem_port;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [2:0]    req_funct3;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_wEn;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_access_type;
  logic [31:0]   mem_dataIn;
  logic [31:0]   mem_dataOut;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram [0:(1<<AW)-1];

  // Results of the last do_req call.
  logic [31:0]   r_rdata;
  logic          r_err;
  int            r_lat;
  int            r_wen_cnt;
  int            r_wen_cyc;
  logic [AW-1:0] r_waddr;
  logic [2:0]    r_wtype;
  logic [31:0]   r_wdat;
  logic          got;

  always #5 clk = ~clk;

  lsu_mem_port #(.ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wEn(mem_wEn), .mem_addr(mem_addr), .mem_access_type(mem_access_type),
    .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  // Synchronous RAM with lane enables selected by access type; read data valid next cycle.
  always @(posedge clk) begin
    if (mem_wEn) begin
      case (mem_access_type)
        3'b000:  ram[mem_addr][7:0]  <= mem_dataIn[7:0];
        3'b001:  ram[mem_addr][15:0] <= mem_dataIn[15:0];
        default: ram[mem_addr]       <= mem_dataIn;
      endcase
    end
    mem_dataOut <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and watch cycles 1..10 after the accept edge.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd);
    @(posedge clk); #1;
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    r_lat = 0; r_wen_cnt = 0; r_wen_cyc = 0; got = 1'b0;
    r_rdata = '0; r_err = 1'b0; r_waddr = '0; r_wtype = '0; r_wdat = '0;
    for (int c = 1; c <= 10 && !got; c++) begin
      if (mem_wEn) begin
        r_wen_cnt++; r_wen_cyc = c; r_waddr = mem_addr; r_wtype = mem_access_type; r_wdat = mem_dataIn;
      end
      if (resp_valid) begin
        got = 1'b1; r_lat = c; r_rdata = resp_rdata; r_err = resp_err;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("resp_seen", {31'b0, got}, 32'd1);
  endtask

  initial begin
    logic [15:0] rv;
    logic [15:0] rdy;
    int pulses;

    for (int i = 0; i < (1<<AW); i++) ram[i] = 32'h0;
    ram[14'h80] = 32'h11223344;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_funct3 = '0; req_wdata = '0;

    // Reset state
    #12;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_wen", {31'b0, mem_wEn}, 32'd0);
    chk("rst_type", {29'b0, mem_access_type}, 32'd2);
    chk("rst_rdata", resp_rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // SW then LW
    do_req(1'b1, 32'h100, 3'b010, 32'hDEADBEEF);
    chk("sw_lat", r_lat, 32'd2);
    chk("sw_err", {31'b0, r_err}, 32'd0);
    chk("sw_rdata", r_rdata, 32'd0);
    chk("sw_wen_cnt", r_wen_cnt, 32'd1);
    chk("sw_waddr", {18'b0, r_waddr}, 32'h40);
    chk("sw_wtype", {29'b0, r_wtype}, 32'd2);
    chk("sw_wdat", r_wdat, 32'hDEADBEEF);
    do_req(1'b0, 32'h100, 3'b010, 32'h0);
    chk("lw_lat", r_lat, 32'd3);
    chk("lw_rdata", r_rdata, 32'hDEADBEEF);
    chk("lw_err", {31'b0, r_err}, 32'd0);
    chk("lw_wen_cnt", r_wen_cnt, 32'd0);

    // RMW byte store; upper wdata bits must be ignored
    do_req(1'b1, 32'h102, 3'b000, 32'h1234565A);
    chk("sb_lat", r_lat, 32'd4);
    chk("sb_wen_cnt", r_wen_cnt, 32'd1);
    chk("sb_wen_cyc", r_wen_cyc, 32'd3);
    chk("sb_wtype", {29'b0, r_wtype}, 32'd2);
    chk("sb_wdat", r_wdat, 32'hDE5ABEEF);

    // Loads with lane select and extension
    do_req(1'b0, 32'h103, 3'b000, 32'h0);
    chk("lb_103", r_rdata, 32'hFFFFFFDE);
    do_req(1'b0, 32'h103, 3'b100, 32'h0);
    chk("lbu_103", r_rdata, 32'h000000DE);
    do_req(1'b0, 32'h102, 3'b001, 32'h0);
    chk("lh_102", r_rdata, 32'hFFFFDE5A);
    do_req(1'b0, 32'h100, 3'b101, 32'h0);
    chk("lhu_100", r_rdata, 32'h0000BEEF);
    do_req(1'b0, 32'h100, 3'b000, 32'h0);
    chk("lb_100", r_rdata, 32'hFFFFFFEF);
    do_req(1'b0, 32'h101, 3'b100, 32'h0);
    chk("lbu_101", r_rdata, 32'h000000BE);

    // RMW upper halfword store and signed reload
    do_req(1'b1, 32'h106, 3'b001, 32'hFFFF8001);
    chk("sh_106_wdat", r_wdat, 32'h80010000);
    do_req(1'b0, 32'h106, 3'b001, 32'h0);
    chk("lh_106", r_rdata, 32'hFFFF8001);

    // Address wrap: high bits ignored
    do_req(1'b0, 32'h0001_0100, 3'b010, 32'h0);
    chk("wrap_lw", r_rdata, 32'hDE5ABEEF);

    // Errors
    do_req(1'b0, 32'h101, 3'b010, 32'h0);
    chk("lw_mis_err", {31'b0, r_err}, 32'd1);
    chk("lw_mis_rdata", r_rdata, 32'd0);
    chk("lw_mis_lat", r_lat, 32'd1);
    chk("lw_mis_wen", r_wen_cnt, 32'd0);
    do_req(1'b1, 32'h103, 3'b001, 32'hFFFFFFFF);
    chk("sh_mis_err", {31'b0, r_err}, 32'd1);
    chk("sh_mis_lat", r_lat, 32'd1);
    chk("sh_mis_wen", r_wen_cnt, 32'd0);
    do_req(1'b0, 32'h100, 3'b010, 32'h0);
    chk("sh_mis_mem", r_rdata, 32'hDE5ABEEF);
    do_req(1'b0, 32'h100, 3'b011, 32'h0);
    chk("ld_f3_011_err", {31'b0, r_err}, 32'd1);
    chk("ld_f3_011_lat", r_lat, 32'd1);
    do_req(1'b1, 32'h100, 3'b100, 32'h0);
    chk("st_f3_100_err", {31'b0, r_err}, 32'd1);
    chk("st_f3_100_wen", r_wen_cnt, 32'd0);

    // Back-to-back requests with req_valid held high
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_funct3 = 3'b010;
    @(posedge clk); #1;
    rv = '0; rdy = '0;
    for (int c = 1; c <= 12; c++) begin
      rv[c]  = resp_valid;
      rdy[c] = req_ready;
      if (c == 4) begin
        @(posedge clk); #1;
        req_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("b2b_resp_pulses", {16'b0, rv}, 32'h0088);
    chk("b2b_ready", {16'b0, rdy}, 32'h1F10);
    chk("b2b_rdata", resp_rdata, 32'hDE5ABEEF);

    // Reset asserted in DATA of a load
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", {31'b0, req_ready}, 32'd1);
    chk("mrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("mrst_rdata", resp_rdata, 32'd0);
    chk("mrst_err", {31'b0, resp_err}, 32'd0);
    chk("mrst_wen", {31'b0, mem_wEn}, 32'd0);
    chk("mrst_addr", {18'b0, mem_addr}, 32'd0);
    chk("mrst_datain", mem_dataIn, 32'd0);
    chk("mrst_type", {29'b0, mem_access_type}, 32'd2);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      pulses += int'(resp_valid);
    end
    chk("mrst_no_resp", pulses, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Word-aligned byte store: direct lane write when enabled, RMW otherwise
    do_req(1'b1, 32'h200, 3'b000, 32'h00000077);
`ifdef LSU_DIRECT_SUBWORD_EN
    chk("sb200_lat", r_lat, 32'd2);
    chk("sb200_wen_cyc", r_wen_cyc, 32'd1);
    chk("sb200_wtype", {29'b0, r_wtype}, 32'd0);
    chk("sb200_wdat", r_wdat, 32'h00000077);
`else
    chk("sb200_lat", r_lat, 32'd4);
    chk("sb200_wen_cyc", r_wen_cyc, 32'd3);
    chk("sb200_wtype", {29'b0, r_wtype}, 32'd2);
    chk("sb200_wdat", r_wdat, 32'h11223377);
`endif
    chk("sb200_wen_cnt", r_wen_cnt, 32'd1);
    do_req(1'b0, 32'h200, 3'b010, 32'h0);
    chk("lw200", r_rdata, 32'h11223377);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
